neuron_accum_ctrl: RTL and testbench

- Sequences one neuron's dot-product accumulation through the sign-magnitude adder datapath (15-bit product + 21-bit accumulator -> 21-bit sum).
- Loads a bias, accepts exactly NUM_INPUTS products over a valid/ready stream, and presents the 21-bit sign-magnitude sum on an output valid/ready port.
- Sits between the multiplier stage and the activation/layer-output logic.

---
 rtl/neuron_accum_ctrl_pkg.sv | 11 +
 rtl/neuron_accum_ctrl_if.sv | 18 +
 rtl/sm_acc_step.sv | 27 ++
 rtl/neuron_accum_ctrl.sv | 54 +++++
 tb/tb_neuron_accum_ctrl.sv | 130 +++++++++++++
 5 files changed

// File: rtl/neuron_accum_ctrl_pkg.sv
// neuron_pkg: shared widths, FSM states and sign-magnitude helpers for neuron_accum_ctrl
package neuron_pkg;
  localparam int SM_IN_W = 15;
  localparam int SM_ACC_W = 21;
  localparam int SM_MAG_W = 20;
  localparam logic [SM_MAG_W-1:0] MAG_MAX = '1;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  function automatic logic [SM_ACC_W-1:0] sm_norm(input logic [SM_ACC_W-1:0] v);
    return {v[SM_ACC_W-1] & |v[SM_MAG_W-1:0], v[SM_MAG_W-1:0]};
  endfunction
endpackage

// File: rtl/neuron_accum_ctrl_if.sv
// neuron_accum_ctrl_if: start/bias, product stream and result stream of the accumulator
interface neuron_accum_ctrl_if;
  import neuron_pkg::*;
  logic start;
  logic [SM_ACC_W-1:0] bias;
  logic in_valid;
  logic in_ready;
  logic [SM_IN_W-1:0] in_data;
  logic out_valid;
  logic out_ready;
  logic [SM_ACC_W-1:0] out_data;
  logic out_ovf;
  logic busy;
  modport master(output start, bias, in_valid, in_data, out_ready,
                 input in_ready, out_valid, out_data, out_ovf, busy);
  modport slave(input start, bias, in_valid, in_data, out_ready,
                output in_ready, out_valid, out_data, out_ovf, busy);
endinterface

// File: rtl/sm_acc_step.sv
// sm_acc_step: one sign-magnitude accumulate step with saturation and -0 normalization
module sm_acc_step
  import neuron_pkg::*;
(
  input  logic [SM_IN_W-1:0]  prod,
  input  logic [SM_ACC_W-1:0] acc,
  output logic [SM_ACC_W-1:0] nxt,
  output logic                ovf
);
  logic [SM_MAG_W-1:0] pm, am, diff, nm;
  logic [SM_MAG_W:0] sum;
  logic ps, as_, same, a_ge, ns;
  always_comb begin
    pm = {{(SM_MAG_W-SM_IN_W+1){1'b0}}, prod[SM_IN_W-2:0]};
    am = acc[SM_MAG_W-1:0];
    ps = prod[SM_IN_W-1];
    as_ = acc[SM_ACC_W-1];
    same = ps == as_;
    sum = {1'b0, am} + {1'b0, pm};
    a_ge = am >= pm;
    diff = a_ge ? am - pm : pm - am;
    ovf = same & sum[SM_MAG_W];
    nm = same ? (ovf ? MAG_MAX : sum[SM_MAG_W-1:0]) : diff;
    ns = same ? as_ : (a_ge ? as_ : ps);
    nxt = sm_norm({ns, nm});
  end
endmodule

// File: rtl/neuron_accum_ctrl.sv
// neuron_accum_ctrl: bias load, NUM_INPUTS-term sign-magnitude accumulation, result handshake.
// Define NEURON_ACCUM_RELU_EN to clamp negative results to zero at the output.
module neuron_accum_ctrl
  import neuron_pkg::*;
#(
  parameter int NUM_INPUTS = 784,
  localparam int CNT_W = $clog2(NUM_INPUTS + 1)
) (
  input logic clk,
  input logic rst,
  neuron_accum_ctrl_if.slave bus
);
  state_t state, nxt_state;
  logic [SM_ACC_W-1:0] acc, step_val;
  logic [CNT_W-1:0] cnt;
  logic ovf, step_ovf, accept, last;
  sm_acc_step u_step (.prod(bus.in_data), .acc(acc), .nxt(step_val), .ovf(step_ovf));
  assign accept = state == ACCUM && bus.in_valid;
  assign last = cnt == CNT_W'(NUM_INPUTS - 1);
  always_comb begin
    nxt_state = state;
    nxt_state = state == IDLE  ? (bus.start ? ACCUM : IDLE) :
                state == ACCUM ? (accept && last ? DONE : ACCUM) :
                state == DONE  ? (bus.out_ready ? IDLE : DONE) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      state <= nxt_state;
      if (state == IDLE && bus.start) begin
        acc <= sm_norm(bus.bias);
        cnt <= '0;
        ovf <= 1'b0;
      end else if (accept) begin
        acc <= step_val;
        cnt <= cnt + CNT_W'(1);
        ovf <= ovf | step_ovf;
      end
    end
  end
  assign bus.in_ready = state == ACCUM;
  assign bus.out_valid = state == DONE;
  assign bus.busy = state != IDLE;
  assign bus.out_ovf = state == DONE && ovf;
`ifdef NEURON_ACCUM_RELU_EN
  assign bus.out_data = state == DONE && !acc[SM_ACC_W-1] ? acc : '0;
`else
  assign bus.out_data = state == DONE ? acc : '0;
`endif
endmodule

// File: tb/tb_neuron_accum_ctrl.sv
// tb_neuron_accum_ctrl: randomized scoreboard bench against an integer-arithmetic reference model
module tb_neuron_accum_ctrl;
  import neuron_pkg::*;
  localparam int NI = 4;
  localparam int MAXM = 20'hFFFFF;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  neuron_accum_ctrl_if bus();
  neuron_accum_ctrl #(.NUM_INPUTS(NI)) dut (.clk(clk), .rst(rst), .bus(bus));
  int tests = 0, fails = 0, cyc = 0;
  logic [21:0] exp_q[$];
  logic [21:0] mon_e;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  function automatic logic [21:0] model(input logic [20:0] b, input logic [14:0] p[NI]);
    int v, q;
    bit o;
    logic [20:0] d;
    o = 0;
    v = b[20] ? -int'(b[19:0]) : int'(b[19:0]);
    for (int k = 0; k < NI; k++) begin
      q = p[k][14] ? -int'(p[k][13:0]) : int'(p[k][13:0]);
      v = v + q;
      if (v > MAXM) begin v = MAXM; o = 1; end
      if (v < -MAXM) begin v = -MAXM; o = 1; end
    end
    d = v < 0 ? {1'b1, 20'(-v)} : {1'b0, 20'(v)};
`ifdef NEURON_ACCUM_RELU_EN
    if (v < 0) d = '0;
`endif
    return {o, d};
  endfunction

  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
      else begin
        mon_e = exp_q.pop_front();
        chk("out_data", 32'(bus.out_data), 32'(mon_e[20:0]));
        chk("out_ovf", 32'(bus.out_ovf), 32'(mon_e[21]));
      end
    end
  end

  task automatic run(input logic [20:0] b, input logic [14:0] p[NI], input bit tog,
                     input int hold, input int abort_after);
    logic [20:0] held;
    int i, g, t0;
    bit ph, acc;
    i = 0; g = 0; ph = 1;
    @(posedge clk); #1;
    bus.bias = b; bus.start = 1;
    exp_q.push_back(model(b, p));
    @(posedge clk); #1;
    t0 = cyc; bus.start = 0;
    while (i < NI && g < 100) begin
      if (i == abort_after) begin
        bus.in_valid = 0; rst = 1;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("abort_idle", {bus.busy, bus.in_ready, bus.out_valid}, 0);
        void'(exp_q.pop_back());
        return;
      end
      bus.in_valid = tog ? ph : 1'b1;
      bus.in_data = p[i];
      ph = !ph;
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (acc) i++;
      g++;
    end
    bus.in_valid = 0;
    if (g >= 100) chk("accept_timeout", i, NI);
    g = 0;
    @(negedge clk);
    while (!bus.out_valid && g < 20) begin @(negedge clk); g++; end
    chk("out_valid_seen", 32'(bus.out_valid), 1);
    if (!tog) chk("latency", cyc - t0, NI);
    held = bus.out_data;
    for (int h = 0; h < hold; h++) begin
      chk("in_ready_done", 32'(bus.in_ready), 0);
      chk("out_valid_hold", 32'(bus.out_valid), 1);
      chk("hold_stable", 32'(bus.out_data), 32'(held));
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.out_ready = 1; bus.start = 1;
    @(posedge clk); #1;
    bus.out_ready = 0; bus.start = 0;
    @(negedge clk);
    chk("idle_after_handoff", {bus.busy, bus.in_ready, bus.out_valid}, 0);
  endtask

  initial begin
    logic [14:0] p[NI];
    logic [20:0] b;
    bus.start = 0; bus.bias = 0; bus.in_valid = 0; bus.in_data = 0; bus.out_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {bus.busy, bus.in_ready, bus.out_valid, bus.out_ovf, bus.out_data}, 0);
    @(posedge clk); #1 rst = 0;
    run(21'h00000A, '{15'h0005, 15'h4003, 15'h4014, 15'h0002}, 0, 0, -1);
    run(21'h100000, '{15'h4003, 15'h0003, 15'h4000, 15'h4000}, 0, 0, -1);
    run(21'h0FFFFF, '{15'h0001, 15'h4001, 15'h0000, 15'h0000}, 0, 1, -1);
    run(21'h000000, '{15'h0000, 15'h0000, 15'h0000, 15'h0000}, 0, 0, -1);
    run(21'h00000A, '{15'h0005, 15'h4003, 15'h4014, 15'h0002}, 1, 5, -1);
    run(21'h00000A, '{15'h0005, 15'h4003, 15'h4014, 15'h0002}, 0, 0, 2);
    run(21'h00000A, '{15'h0005, 15'h4003, 15'h4014, 15'h0002}, 0, 0, -1);
    run(21'h000014, '{15'h0005, 15'h4003, 15'h4014, 15'h0002}, 0, 0, -1);
    for (int r = 0; r < 30; r++) begin
      b = {1'($urandom), $urandom_range(0, 3) == 0 ? 20'(MAXM - $urandom_range(0, 40000)) : 20'($urandom)};
      for (int k = 0; k < NI; k++) p[k] = 15'($urandom);
      run(b, p, 1'($urandom), $urandom_range(0, 3), -1);
    end
    @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
